pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator. It supersedes the fixed 3-channel, 7-bit PWM block. It drives CHANNELS independent outputs from one shared prescaler and one shared period counter, with two modes: linear duty, and servo (pulse mapped into a LO..HI window). Duty and mode changes are double-buffered and applied only at a period boundary, so outputs never glitch. It sits between the register/pin interface and the PWM output pads.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_multi_ch_if.sv | 25 ++
 rtl/pwm_prescaler.sv | 30 +++
 rtl/pwm_multi_ch.sv | 100 ++++++++++
 tb/tb_pwm_multi_ch.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode encodings,
// default timing constants and the servo threshold mapping.
package pwm_pkg;

    typedef enum logic {
        MODE_LIN   = 1'b0,
        MODE_SERVO = 1'b1
    } pwm_mode_e;

    localparam int DEF_DIV_LIN   = 40;
    localparam int DEF_DIV_SERVO = 7813;
    localparam int DEF_SERVO_LO  = 13;
    localparam int DEF_SERVO_HI  = 26;

    // Full-width product before the shift so small windows keep their resolution.
    function automatic logic [31:0] servo_thr(input logic [31:0] duty,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi,
                                              input int          width);
        logic [63:0] prod;
        prod = 64'(duty) * 64'(hi - lo);
        return lo + 32'(prod >> width);
    endfunction

endpackage

// File: rtl/pwm_multi_ch_if.sv
// Register/pin side bundle of the PWM block plus debug taps of its counters.
// No handshake: en_i/mode_i/duty_i are level inputs sampled every clock,
// pwm_o/period_o are registered outputs, dbg_* mirror the live counters.
interface pwm_multi_ch_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
);
    logic                         en_i;
    logic                         mode_i;
    logic [CHANNELS*WIDTH-1:0]    duty_i;
    logic [CHANNELS-1:0]          pwm_o;
    logic                         period_o;
    logic [WIDTH-1:0]             dbg_cnt;
    logic [31:0]                  dbg_div_cnt;

    modport master (
        output en_i, mode_i, duty_i,
        input  pwm_o, period_o, dbg_cnt, dbg_div_cnt
    );

    modport slave (
        input  en_i, mode_i, duty_i,
        output pwm_o, period_o, dbg_cnt, dbg_div_cnt
    );
endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..div-1 while enabled and pulses tick on the last
// count; held at zero when disabled.
module pwm_prescaler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] div,
    output logic        tick,
    output logic [31:0] div_cnt
);
    logic [31:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = en_i && (div_cnt_q == div - 32'd1);
        div_cnt_d = div_cnt_q + 32'd1;
        if (!en_i || tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign div_cnt = div_cnt_q;
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel compare
// against double-buffered duty/mode shadows that reload only at period wrap.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int                   CHANNELS  = 3,
    parameter int                   WIDTH     = 8,
    parameter int                   DIV_LIN   = DEF_DIV_LIN,
    parameter int                   DIV_SERVO = DEF_DIV_SERVO,
    parameter int                   SERVO_LO  = DEF_SERVO_LO,
    parameter int                   SERVO_HI  = DEF_SERVO_HI,
    parameter logic [CHANNELS-1:0]  POL       = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pwm_multi_ch_if.slave  bus
);
    localparam int TW = WIDTH + 1;

    logic                      tick;
    logic                      wrap;
    logic [31:0]               div_sel;
    logic [31:0]               div_cnt;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic                      mode_sh_q, mode_sh_d;
    logic [CHANNELS-1:0]       active;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_q, period_d;

    // Tick rate follows the shadow mode so DIV and mapping switch together.
    assign div_sel = (mode_sh_q == MODE_SERVO) ? 32'(DIV_SERVO) : 32'(DIV_LIN);

    pwm_prescaler u_prescaler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (bus.en_i),
        .div     (div_sel),
        .tick    (tick),
        .div_cnt (div_cnt)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] duty;
        logic [TW-1:0]    thr;

        assign duty = duty_sh_q[c*WIDTH +: WIDTH];

        always_comb begin
            thr = {1'b0, duty};
            if (mode_sh_q == MODE_SERVO) begin
                thr = TW'(servo_thr(32'(duty), 32'(SERVO_LO), 32'(SERVO_HI), WIDTH));
            end
        end

        assign active[c] = ({1'b0, cnt_q} < thr);
    end

    always_comb begin
        wrap      = tick && (cnt_q == {WIDTH{1'b1}});
        cnt_d     = cnt_q;
        duty_sh_d = duty_sh_q;
        mode_sh_d = mode_sh_q;
        pwm_d     = POL;
        period_d  = wrap;
        if (!bus.en_i) begin
            cnt_d = '0;
        end else begin
            pwm_d = active ^ POL;
            if (tick) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (!bus.en_i || wrap) begin
            duty_sh_d = bus.duty_i;
            mode_sh_d = bus.mode_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            duty_sh_q <= '0;
            mode_sh_q <= 1'b0;
            pwm_q     <= POL;
            period_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            duty_sh_q <= duty_sh_d;
            mode_sh_q <= mode_sh_d;
            pwm_q     <= pwm_d;
            period_q  <= period_d;
        end
    end

    assign bus.pwm_o       = pwm_q;
    assign bus.period_o    = period_q;
    assign bus.dbg_cnt     = cnt_q;
    assign bus.dbg_div_cnt = div_cnt;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: a small linear/servo instance with an
// inverted channel and a full-size servo instance, checked per period window.
module tb_pwm_multi_ch;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    pwm_multi_ch_if #(.CHANNELS(3), .WIDTH(4)) bus_a ();
    pwm_multi_ch_if #(.CHANNELS(3), .WIDTH(8)) bus_b ();

    pwm_multi_ch #(
        .CHANNELS(3), .WIDTH(4), .DIV_LIN(2), .DIV_SERVO(3),
        .SERVO_LO(3), .SERVO_HI(12), .POL(3'b010)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    pwm_multi_ch #(
        .CHANNELS(3), .WIDTH(8), .DIV_LIN(2), .DIV_SERVO(1),
        .SERVO_LO(13), .SERVO_HI(26), .POL(3'b000)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Steps until period_o of the selected instance, returns cycles waited.
    task automatic wait_period(input bit sel_b, output int n);
        n = 0;
        while (!(sel_b ? bus_b.period_o : bus_a.period_o) && n < 600) begin
            step();
            n++;
        end
    endtask

    // Starting on a period_o cycle, measures one period: length, raw high
    // counts per channel and toggles of ch1; optional mid-period action on A.
    task automatic win(input bit sel_b, input int act_at, input int act_kind,
                       output int len, output int hi0, output int hi1,
                       output int hi2, output int tog1);
        logic [2:0] p;
        logic       prev1;
        len = 0; hi0 = 0; hi1 = 0; hi2 = 0; tog1 = 0;
        prev1 = 1'b0;
        do begin
            if (len == act_at) begin
                case (act_kind)
                    1: begin
                        check("mid_cnt", 32'(bus_a.dbg_cnt), 32'd6);
                        bus_a.duty_i[7:4] = 4'd12;
                    end
                    2: bus_a.duty_i[3:0] = 4'd2;
                    3: bus_a.mode_i = 1'b1;
                    default: ;
                endcase
            end
            p = sel_b ? bus_b.pwm_o : bus_a.pwm_o;
            hi0 += int'(p[0]);
            hi1 += int'(p[1]);
            hi2 += int'(p[2]);
            if (len > 0 && p[1] != prev1) tog1++;
            prev1 = p[1];
            step();
            len++;
        end while (!(sel_b ? bus_b.period_o : bus_a.period_o) && len < 600);
    endtask

    task automatic wait_cnt_a(input int v, output int n);
        n = 0;
        while (32'(bus_a.dbg_cnt) != 32'(v) && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, len, h0, h1, h2, tg, bad_a, bad_b;

        rst = 1'b1;
        bus_a.en_i = 1'b0; bus_a.mode_i = 1'b0; bus_a.duty_i = '0;
        bus_b.en_i = 1'b0; bus_b.mode_i = 1'b0; bus_b.duty_i = '0;
        repeat (3) step();
        check("rst_pwm_a",    32'(bus_a.pwm_o), 32'd2);
        check("rst_pwm_b",    32'(bus_b.pwm_o), 32'd0);
        check("rst_period_a", 32'(bus_a.period_o), 32'd0);
        check("rst_cnt_a",    32'(bus_a.dbg_cnt), 32'd0);
        rst = 1'b0;

        // idle for 100 cycles with new duties on the pins
        bus_a.duty_i = {4'd15, 4'd5, 4'd0};
        bus_b.duty_i = {8'd255, 8'd128, 8'd0};
        bus_b.mode_i = 1'b1;
        bad_a = 0; bad_b = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_a.pwm_o != 3'b010 || bus_a.period_o || bus_a.dbg_cnt != 0 || bus_a.dbg_div_cnt != 0) bad_a++;
            if (bus_b.pwm_o != 3'b000 || bus_b.period_o || bus_b.dbg_cnt != 0 || bus_b.dbg_div_cnt != 0) bad_b++;
        end
        check("idle_a", 32'(bad_a), 32'd0);
        check("idle_b", 32'(bad_b), 32'd0);

        // linear {0,5,15}, 32-clock periods, ch1 inverted
        bus_a.en_i = 1'b1;
        wait_period(1'b0, n);
        check("lin_first_period", 32'(n), 32'd32);
        win(1'b0, -1, 0, len, h0, h1, h2, tg);
        check("lin_len", 32'(len), 32'd32);
        check("lin_ch0", 32'(h0), 32'd0);
        check("lin_ch1_raw", 32'(h1), 32'd22);
        check("lin_ch2", 32'(h2), 32'd30);
        win(1'b0, -1, 0, len, h0, h1, h2, tg);
        check("lin_len2", 32'(len), 32'd32);

        // servo {0,128,255} -> 13/19/25 of 256
        bus_b.en_i = 1'b1;
        wait_period(1'b1, n);
        check("srv_first_period", 32'(n), 32'd256);
        win(1'b1, -1, 0, len, h0, h1, h2, tg);
        check("srv_len", 32'(len), 32'd256);
        check("srv_ch0", 32'(h0), 32'd13);
        check("srv_ch1", 32'(h1), 32'd19);
        check("srv_ch2", 32'(h2), 32'd25);

        // mid-period duty update on A
        bus_a.en_i = 1'b0;
        step();
        bus_a.duty_i = {4'd8, 4'd4, 4'd4};
        bus_a.mode_i = 1'b0;
        step();
        bus_a.en_i = 1'b1;
        wait_period(1'b0, n);
        check("upd_first_period", 32'(n), 32'd32);
        win(1'b0, 12, 1, len, h0, h1, h2, tg);
        check("upd_w1_ch1_raw", 32'(h1), 32'd24);
        check("upd_w1_tog", 32'(tg), 32'd2);
        check("upd_w1_ch0", 32'(h0), 32'd8);
        check("upd_w1_ch2", 32'(h2), 32'd16);
        win(1'b0, 31, 2, len, h0, h1, h2, tg);
        check("upd_w2_ch1_raw", 32'(h1), 32'd8);
        check("upd_w2_tog", 32'(tg), 32'd2);
        check("upd_w2_ch0", 32'(h0), 32'd8);
        win(1'b0, -1, 0, len, h0, h1, h2, tg);
        check("wrapwr_w3_ch0", 32'(h0), 32'd4);
        check("wrapwr_w3_ch1_raw", 32'(h1), 32'd8);

        // mode switch mid-period: takes effect at next wrap
        win(1'b0, 10, 3, len, h0, h1, h2, tg);
        check("msw_w4_len", 32'(len), 32'd32);
        check("msw_w4_ch0", 32'(h0), 32'd4);
        check("msw_w4_ch1_raw", 32'(h1), 32'd8);
        check("msw_w4_ch2", 32'(h2), 32'd16);
        win(1'b0, -1, 0, len, h0, h1, h2, tg);
        check("msw_w5_len", 32'(len), 32'd48);
        check("msw_w5_ch0", 32'(h0), 32'd12);
        check("msw_w5_ch1_raw", 32'(h1), 32'd21);
        check("msw_w5_ch2", 32'(h2), 32'd21);

        // en_i drop at cnt=9
        wait_cnt_a(9, n);
        check("drop_found", 32'(bus_a.dbg_cnt), 32'd9);
        bus_a.en_i = 1'b0;
        step();
        check("drop_cnt", 32'(bus_a.dbg_cnt), 32'd0);
        check("drop_div", bus_a.dbg_div_cnt, 32'd0);
        check("drop_pwm", 32'(bus_a.pwm_o), 32'd2);
        check("drop_period", 32'(bus_a.period_o), 32'd0);

        // reset pulse at cnt=3 of a new run
        bus_a.en_i = 1'b1;
        wait_cnt_a(3, n);
        check("rstp_found", 32'(bus_a.dbg_cnt), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstp_cnt", 32'(bus_a.dbg_cnt), 32'd0);
        check("rstp_div", bus_a.dbg_div_cnt, 32'd0);
        check("rstp_pwm", 32'(bus_a.pwm_o), 32'd2);
        check("rstp_pwm_b", 32'(bus_b.pwm_o), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
